// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: byte FIFO feeding an 8N1 UART transmitter with registered serial output
module uart_tx_fifo #(
  parameter int CLOCK_FREQ = 50_000_000,
  parameter int BAUD_RATE  = 115_200,
  parameter int FIFO_DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] data_in,
  input  logic       data_in_valid,
  output logic       data_in_ready,
  output logic       busy,
  output logic       serial_out
);
  localparam int SYMBOL = CLOCK_FREQ / BAUD_RATE;
  localparam int CW = $clog2(SYMBOL);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int NW = AW + 1;
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
  state_t state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [2:0] bit_idx, bit_n;
  logic [7:0] shift, shift_n;
  logic [7:0] mem [FIFO_DEPTH];
  logic [AW-1:0] rd, wr;
  logic [NW-1:0] count, count_n;
  logic push, pop, last, serial_n;
  assign data_in_ready = rst && (count < NW'(FIFO_DEPTH));
  assign push = data_in_valid && data_in_ready;
  assign last = cnt == CW'(SYMBOL - 1);
  // next-state logic: symbol timing, bit sequencing and FIFO pops
  always_comb begin
    state_n = state;
    cnt_n = (state == IDLE || last) ? '0 : cnt + 1'b1;
    bit_n = bit_idx;
    shift_n = shift;
    pop = 1'b0;
    case (state)
      IDLE: if (count != '0) begin
        pop = 1'b1;
        shift_n = mem[rd];
        state_n = START;
      end
      START: if (last) begin
        state_n = DATA;
        bit_n = '0;
      end
      DATA: if (last) begin
        shift_n = shift >> 1;
        bit_n = bit_idx + 3'd1;
        state_n = (bit_idx == 3'd7) ? STOP : DATA;
      end
      STOP: if (last) begin
        pop = count != '0;
        shift_n = pop ? mem[rd] : shift;
        state_n = pop ? START : IDLE;
      end
      default: state_n = IDLE;
    endcase
    count_n = count + NW'(push) - NW'(pop);
    serial_n = (state_n == START) ? 1'b0 : (state_n == DATA) ? shift_n[0] : 1'b1;
  end
  // state, pointer and registered output updates
  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= IDLE;
      cnt <= '0;
      bit_idx <= '0;
      shift <= '0;
      rd <= '0;
      wr <= '0;
      count <= '0;
      busy <= 1'b0;
      serial_out <= 1'b1;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      bit_idx <= bit_n;
      shift <= shift_n;
      rd <= rd + AW'(pop);
      wr <= wr + AW'(push);
      count <= count_n;
      busy <= (state_n != IDLE) || (count_n != '0);
      serial_out <= serial_n;
    end
  end
  // FIFO storage; push is already gated off during reset
  always_ff @(posedge clk) begin
    if (push) mem[wr] <= data_in;
  end
endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb_uart_tx_fifo: directed + random stimulus against a frame-timeline reference model
module tb_uart_tx_fifo;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic [7:0] data_in = 8'h00;
  logic data_in_valid = 1'b0;
  logic data_in_ready, busy, serial_out;
  int checks = 0, failures = 0, e = 0, n_push = 0, last_start = -1000;
  int f_start[$];
  logic [7:0] f_data[$];
  logic [7:0] rx[$];
  logic [7:0] exp_q[$];
  bit dec_on = 0;
  int dec_cnt = 0;
  logic [7:0] dec_byte = 8'h00;
  bit pushed;
  int idx, s0, guard;

  uart_tx_fifo #(.CLOCK_FREQ(1000), .BAUD_RATE(100), .FIFO_DEPTH(4)) dut (
    .clk(clk), .rst(rst), .data_in(data_in), .data_in_valid(data_in_valid),
    .data_in_ready(data_in_ready), .busy(busy), .serial_out(serial_out));

  always #5 clk = ~clk;

  function automatic int started();
    int n = 0;
    foreach (f_start[i]) if (f_start[i] <= e) n++;
    return n;
  endfunction

  function automatic logic in_frame();
    foreach (f_start[i]) if (f_start[i] <= e && e < f_start[i] + 100) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic exp_line();
    foreach (f_start[i]) begin
      if (f_start[i] <= e && e < f_start[i] + 100) begin
        int k = (e - f_start[i]) / 10;
        if (k == 0) return 1'b0;
        if (k == 9) return 1'b1;
        return f_data[i][k-1];
      end
    end
    return 1'b1;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s at edge %0d: observed %0h expected %0h", tag, e, obs, expv);
    end
  endtask

  // one clock: drive inputs, advance the model at the edge, check outputs at the negedge
  task automatic cyc(input logic v, input logic [7:0] d, input logic r, output bit p);
    int s;
    data_in_valid = v;
    data_in = d;
    rst = r;
    p = r && v && (n_push - started() < 4);
    @(posedge clk);
    e++;
    if (!r) begin
      f_start.delete();
      f_data.delete();
      n_push = 0;
      last_start = -1000;
      dec_on = 0;
    end else if (p) begin
      s = (e + 1 > last_start + 100) ? e + 1 : last_start + 100;
      f_start.push_back(s);
      f_data.push_back(d);
      last_start = s;
      n_push++;
    end
    @(negedge clk);
    chk("serial_out", 32'(serial_out), 32'(exp_line()));
    chk("busy", 32'(busy), 32'((n_push - started() > 0) || in_frame()));
    chk("ready", 32'(data_in_ready), 32'(r && (n_push - started() < 4)));
    if (r) begin
      if (!dec_on) begin
        if (serial_out === 1'b0) begin
          dec_on = 1;
          dec_cnt = 0;
        end
      end else begin
        dec_cnt++;
        if (dec_cnt % 10 == 5 && dec_cnt >= 15 && dec_cnt <= 85) dec_byte[(dec_cnt - 15) / 10] = serial_out;
        if (dec_cnt == 95) begin
          chk("stop_bit", 32'(serial_out), 32'd1);
          rx.push_back(dec_byte);
        end
        if (dec_cnt == 99) dec_on = 0;
      end
    end
  endtask

  task automatic idle(input int n);
    bit p;
    for (int i = 0; i < n; i++) cyc(1'b0, 8'($urandom), 1'b1, p);
  endtask

  task automatic drain(input string tag);
    bit p;
    int n = 0;
    while ((busy || dec_on) && n < 3000) begin
      cyc(1'b0, 8'h00, 1'b1, p);
      n++;
    end
    chk(tag, 32'(n < 3000), 32'd1);
    idle(3);
  endtask

  task automatic chk_rx(input string tag);
    chk({tag, "_len"}, 32'(rx.size()), 32'(exp_q.size()));
    foreach (exp_q[i]) chk(tag, (i < rx.size()) ? 32'(rx[i]) : 32'hffff_ffff, 32'(exp_q[i]));
    rx.delete();
    exp_q.delete();
  endtask

  initial begin
    for (int i = 0; i < 5; i++) cyc(1'b1, 8'h99, 1'b0, pushed);
    idle(5);
    chk("reset_no_tx", 32'(rx.size()), 32'd0);
    cyc(1'b1, 8'h55, 1'b1, pushed);
    chk("single_push", 32'(pushed), 32'd1);
    drain("single_timeout");
    exp_q = '{8'h55};
    chk_rx("single_rx");
    idx = 0;
    guard = 0;
    while (idx < 5 && guard < 1000) begin
      cyc(1'b1, 8'h41 + 8'(idx), 1'b1, pushed);
      if (pushed) idx++;
      guard++;
    end
    chk("burst_timeout", 32'(idx), 32'd5);
    drain("burst_drain");
    exp_q = '{8'h41, 8'h42, 8'h43, 8'h44, 8'h45};
    chk_rx("burst_rx");
    for (int i = 0; i < 3; i++) begin
      cyc(1'b1, 8'($urandom), 1'b1, pushed);
      exp_q.push_back(data_in);
    end
    s0 = f_start[f_start.size() - 3];
    while (e < s0 + 99) cyc(1'b0, 8'h00, 1'b1, pushed);
    cyc(1'b1, 8'($urandom), 1'b1, pushed);
    exp_q.push_back(data_in);
    chk("simul_push", 32'(pushed), 32'd1);
    chk("simul_count", 32'(n_push - started()), 32'd2);
    drain("simul_drain");
    chk_rx("simul_rx");
    cyc(1'b1, 8'hFF, 1'b1, pushed);
    cyc(1'b1, 8'h00, 1'b1, pushed);
    s0 = f_start[f_start.size() - 2];
    while (e < s0 + 44) cyc(1'b0, 8'h00, 1'b1, pushed);
    cyc(1'b0, 8'h00, 1'b0, pushed);
    chk("abort_line", 32'(serial_out), 32'd1);
    idle(200);
    chk("abort_no_rx", 32'(rx.size()), 32'd0);
    cyc(1'b1, 8'hA5, 1'b1, pushed);
    drain("post_reset_drain");
    exp_q = '{8'hA5};
    chk_rx("post_reset_rx");
    idx = 0;
    guard = 0;
    while (idx < 16 && guard < 5000) begin
      cyc($urandom_range(0, 2) != 0, 8'(idx), 1'b1, pushed);
      if (pushed) begin
        exp_q.push_back(8'(idx));
        idx++;
      end
      guard++;
    end
    chk("wrap_timeout", 32'(idx), 32'd16);
    drain("wrap_drain");
    chk_rx("wrap_rx");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/uart_tx_fifo.md
Name: uart_tx_fifo

Overview:
- Serial transmit path downstream of the Riscv151 memory-mapped UART data register; drives FPGA_SERIAL_TX.
- CPU-side logic pushes bytes through a valid/ready handshake into a small FIFO.
- A bit-timing FSM serialises each byte as 8N1: start bit, 8 data bits LSB first, stop bit.
- Buffering lets the CPU write several characters back to back without polling between them.

Parameters:
- CLOCK_FREQ, 50_000_000: core clock in Hz.
- BAUD_RATE, 115_200: serial bit rate.
- FIFO_DEPTH, 4: byte entries; must be a power of two and at least 2.

Ports:
- clk  in  1  core clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-low reset: rst==0 sampled at a posedge resets the block.
- data_in  in  8  byte to transmit.
- data_in_valid  in  1  producer offers data_in this cycle.
- data_in_ready  out  1  block can accept a byte this cycle.
- busy  out  1  FIFO non-empty or frame in progress.
- serial_out  out  1  UART line, idle high; connects to FPGA_SERIAL_TX.

Behaviour:
- Timing constants:
  - SYMBOL = CLOCK_FREQ/BAUD_RATE, integer truncation; SYMBOL >= 2 is required.
  - Bit counter width is clog2(SYMBOL).
  - Occupancy count width is clog2(FIFO_DEPTH)+1.
- Reset (rst==0 at posedge):
  - FIFO flushed (rd ptr = wr ptr = count = 0); FSM to IDLE; counters cleared.
  - serial_out=1, busy=0, registered from the next edge.
  - data_in_ready is forced 0 combinationally while rst==0.
  - Reset mid-frame aborts the frame immediately; the line returns high on the next cycle and the partial byte is lost.
- Push:
  - data_in_ready = rst && (count < FIFO_DEPTH), combinational from registered count.
  - A byte is written when data_in_valid && data_in_ready at a posedge.
  - While data_in_valid is low, data_in is don't-care.
- Pop: the FSM pops the FIFO head when in IDLE with count>0, or at the final cycle of STOP with count>0.
- Simultaneous push and pop in one cycle: count is unchanged and both pointers advance; legal at any occupancy below full.
  - At full, ready=0, so no push occurs.
  - The slot freed by a pop is visible as ready=1 in the following cycle.
- FSM states: IDLE, START, DATA, STOP; a symbol counter runs 0..SYMBOL-1.
  - IDLE: serial_out=1. If count>0, pop into a shift register and go to START with counter=0.
  - START: serial_out=0 for SYMBOL cycles, then DATA with bit index 0.
  - DATA: serial_out=shift[0] for SYMBOL cycles per bit. Shift right at the end of each bit. After bit 7, go to STOP.
  - STOP: serial_out=1 for SYMBOL cycles. At the last cycle, if count>0, pop and go to START (no idle gap); otherwise go to IDLE.
- serial_out is a register output (glitch-free).
- Latency: a byte pushed into an empty FIFO while IDLE at edge N gives:
  - IDLE pops at edge N+1.
  - serial_out falls at edge N+1.
  - Frame occupies exactly 10*SYMBOL cycles.
- Back-to-back frames are exactly 10*SYMBOL cycles apart; there are no extra high cycles between stop and start.
- busy = (state != IDLE) || (count != 0), registered.
- Wrap-around:
  - Pointers are clog2(FIFO_DEPTH) bits and wrap naturally.
  - Full/empty are decided from count only.

Test Plan (bench uses CLOCK_FREQ=1000, BAUD_RATE=100 -> SYMBOL=10):
1. Reset: hold rst=0 for 5 cycles with data_in_valid=1 -> data_in_ready=0, serial_out=1, busy=0 throughout; no byte enters the FIFO.
2. Single byte: push 8'h55 in one cycle -> serial_out falls one cycle later. Line reads 0,1,0,1,0,1,0,1,0,1 (start, LSB-first data, stop), each held exactly 10 cycles. busy drops after 100 cycles.
3. Burst/full: push 8'h41,8'h42,8'h43,8'h44,8'h45 with valid held high -> the first 4 are accepted. After the 4th accepted push (first byte already popped), the 5th is accepted and ready drops to 0 at count=4. ready returns to 1 one cycle after the next pop. Decoded line stream is "ABCDE" with no gaps, 500 cycles total.
4. Simultaneous push/pop: with count=2, push exactly on the STOP-final cycle -> count stays 2, no byte lost or duplicated, order preserved.
5. Reset mid-frame: push 8'hFF then 8'h00; assert rst=0 during DATA bit 3 -> serial_out=1 next cycle. FIFO empty, 8'h00 never transmitted. A post-reset push of 8'hA5 transmits correctly.
6. Wrap-around: stream 16 sequential bytes 8'h00..8'h0F with random valid gaps -> the decoder receives all 16 in order, confirming pointer wrap at depth 4.
